sram_pattern_tester: RTL and testbench

SRAM_PATTERN_TESTER -- requirements
Module: sram_pattern_tester

---
 rtl/sram_pattern_tester_pkg.sv | 24 ++
 rtl/sram_addr_counter.sv | 37 +++
 rtl/sram_pattern_tester.sv | 171 +++++++++++++++++
 tb/tb_sram_pattern_tester.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pattern_tester_pkg.sv
// Shared constants for the SRAM pattern tester: FSM state encoding,
// pattern count and a busy-state helper used by the tester and its bench.
package sram_pattern_tester_pkg;

    localparam int PATTERN_COUNT    = 7;
    localparam int PATTERN_IDX_BITS = 3;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_GEN_RST   = 4'd1,
        S_WRITE     = 4'd2,
        S_READ      = 4'd3,
        S_READ_WAIT = 4'd4,
        S_ADVANCE   = 4'd5,
        S_SETTLE    = 4'd6,
        S_DONE_PASS = 4'd7,
        S_DONE_FAIL = 4'd8
    } state_e;

    function automatic logic state_busy(state_e s);
        return !(s inside {S_IDLE, S_DONE_PASS, S_DONE_FAIL});
    endfunction

endpackage

// File: rtl/sram_addr_counter.sv
// SRAM address counter with synchronous clear, increment (natural wrap)
// and last-address detect. Ports: clk_i, rst_ni, clr_i, inc_i, addr_o, last_o.
module sram_addr_counter #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 last_o
);

    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (inc_i) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = &addr_q;

endmodule

// File: rtl/sram_pattern_tester.sv
// SRAM pattern tester: writes each generator pattern to every address,
// reads back and compares, stopping at the first mismatch.
// Ports: clk, reset_n, start; gen_reset/gen_next/gen_pattern/gen_done to
// the pattern generator; mem_req/we/addr/wdata/ready/rdata/rvalid to the
// SRAM controller; busy, pass, fail, fail_addr/expected/actual, pattern_idx.
module sram_pattern_tester
    import sram_pattern_tester_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    output logic                        gen_reset,
    output logic                        gen_next,
    input  logic [DATA_BITS-1:0]        gen_pattern,
    input  logic                        gen_done,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_BITS-1:0]        mem_addr,
    output logic [DATA_BITS-1:0]        mem_wdata,
    input  logic                        mem_ready,
    input  logic [DATA_BITS-1:0]        mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        busy,
    output logic                        pass,
    output logic                        fail,
    output logic [ADDR_BITS-1:0]        fail_addr,
    output logic [DATA_BITS-1:0]        fail_expected,
    output logic [DATA_BITS-1:0]        fail_actual,
    output logic [PATTERN_IDX_BITS-1:0] pattern_idx
);

    state_e                        state_q, state_d;
    logic                          pass_q, pass_d;
    logic                          fail_q, fail_d;
    logic [ADDR_BITS-1:0]          faddr_q, faddr_d;
    logic [DATA_BITS-1:0]          fexp_q, fexp_d;
    logic [DATA_BITS-1:0]          fact_q, fact_d;
    logic [PATTERN_IDX_BITS-1:0]   idx_q, idx_d;
    logic                          gen_reset_q;
    logic                          gen_next_q;
    logic                          cnt_clr;
    logic                          cnt_inc;
    logic [ADDR_BITS-1:0]          addr;
    logic                          addr_last;

    sram_addr_counter #(
        .ADDR_BITS(ADDR_BITS)
    ) u_addr (
        .clk_i (clk),
        .rst_ni(reset_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .addr_o(addr),
        .last_o(addr_last)
    );

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        faddr_d = faddr_q;
        fexp_d  = fexp_q;
        fact_d  = fact_q;
        idx_d   = idx_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE_PASS, S_DONE_FAIL: begin
                if (start) begin
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    faddr_d = '0;
                    fexp_d  = '0;
                    fact_d  = '0;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = S_GEN_RST;
                end
            end
            S_GEN_RST: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ready) begin
                    cnt_inc = 1'b1;
                    if (addr_last) begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    state_d = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rdata != gen_pattern) begin
                        faddr_d = addr;
                        fexp_d  = gen_pattern;
                        fact_d  = mem_rdata;
                        fail_d  = 1'b1;
                        state_d = S_DONE_FAIL;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = addr_last ? S_ADVANCE : S_READ;
                    end
                end
            end
            S_ADVANCE: begin
                idx_d   = idx_q + 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (gen_done) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE_PASS;
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Generator strobes are flopped from the next state so they are
    // glitch-free and high exactly for the cycle spent in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            faddr_q     <= '0;
            fexp_q      <= '0;
            fact_q      <= '0;
            idx_q       <= '0;
            gen_reset_q <= 1'b0;
            gen_next_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            faddr_q     <= faddr_d;
            fexp_q      <= fexp_d;
            fact_q      <= fact_d;
            idx_q       <= idx_d;
            gen_reset_q <= (state_d == S_GEN_RST);
            gen_next_q  <= (state_d == S_ADVANCE);
        end
    end

    assign gen_reset     = gen_reset_q;
    assign gen_next      = gen_next_q;
    assign mem_req       = (state_q == S_WRITE) || (state_q == S_READ);
    assign mem_we        = (state_q == S_WRITE);
    assign mem_addr      = addr;
    assign mem_wdata     = gen_pattern;
    assign busy          = state_busy(state_q);
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign fail_addr     = faddr_q;
    assign fail_expected = fexp_q;
    assign fail_actual   = fact_q;
    assign pattern_idx   = idx_q;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Bench for sram_pattern_tester: generator + SRAM models with stalls,
// read latency and stuck-at faults, checked against spec-level expectations.
module tb_sram_pattern_tester;
    import sram_pattern_tester_pkg::*;

    localparam int AB    = 4;
    localparam int DB    = 16;
    localparam int DEPTH = 1 << AB;
    localparam int OPS   = PATTERN_COUNT * DEPTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          gen_reset, gen_next, gen_done;
    logic [DB-1:0] gen_pattern;
    logic          mem_req, mem_we, mem_ready;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_wdata;
    logic [DB-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          busy, pass, fail;
    logic [AB-1:0] fail_addr;
    logic [DB-1:0] fail_expected, fail_actual;
    logic [2:0]    pattern_idx;

    always #5 clk = ~clk;

    sram_pattern_tester #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .gen_reset(gen_reset), .gen_next(gen_next),
        .gen_pattern(gen_pattern), .gen_done(gen_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy), .pass(pass), .fail(fail), .fail_addr(fail_addr),
        .fail_expected(fail_expected), .fail_actual(fail_actual),
        .pattern_idx(pattern_idx)
    );

    // pattern generator model: 7 patterns, index 0 = all zeros, 1 = all ones
    logic [DB-1:0] pats [8] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555,
                                16'h0F0F, 16'hF0F0, 16'h3333, 16'h0000};
    logic [2:0] gidx = 3'd0;
    always @(posedge clk) begin
        if (gen_reset) gidx <= 3'd0;
        else if (gen_next && gidx != 3'd7) gidx <= gidx + 3'd1;
    end
    assign gen_pattern = pats[gidx];
    assign gen_done    = (gidx == 3'd7);

    // SRAM model: configurable stalls, read latency and a stuck-at bit
    logic [DB-1:0] mem [DEPTH];
    int            stall_mode = 0;
    int            rd_lat = 1;
    int            wait_cnt = 0;
    int            rnd_tgt = 0;
    int            tgt;
    int            rd_cnt = 0;
    logic [DB-1:0] rd_hold = '0;
    logic          flt_en = 1'b0;
    logic [AB-1:0] flt_addr = '0;
    int            flt_bit = 0;
    logic          flt_val = 1'b0;

    function automatic logic [DB-1:0] sram_out(logic [AB-1:0] a, logic [DB-1:0] d);
        logic [DB-1:0] r = d;
        if (flt_en && a == flt_addr) r[flt_bit] = flt_val;
        return r;
    endfunction

    always_comb begin
        tgt = 0;
        if (stall_mode == 1) tgt = 3;
        else if (stall_mode == 2) tgt = rnd_tgt;
        mem_ready = mem_req && (wait_cnt >= tgt);
    end

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= rd_hold;
            end
        end
        if (!mem_req) begin
            wait_cnt <= 0;
        end else if (mem_ready) begin
            wait_cnt <= 0;
            rnd_tgt  <= int'($urandom_range(0, 3));
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else if (rd_lat <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= sram_out(mem_addr, mem[mem_addr]);
            end else begin
                rd_hold <= sram_out(mem_addr, mem[mem_addr]);
                rd_cnt  <= rd_lat - 1;
            end
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // free-running event monitor sampled on the falling edge
    int            n_wr = 0, n_rd = 0, n_gn = 0, n_gr = 0;
    int            n_stall = 0, n_stab = 0, n_both = 0;
    logic          p_stall = 1'b0;
    logic          p_we = 1'b0;
    logic [AB-1:0] p_addr = '0;
    logic [DB-1:0] p_wdata = '0;
    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) n_wr <= n_wr + 1;
            else n_rd <= n_rd + 1;
        end
        if (gen_next) n_gn <= n_gn + 1;
        if (gen_reset) n_gr <= n_gr + 1;
        if (pass && fail) n_both <= n_both + 1;
        if (p_stall && reset_n &&
            (!mem_req || mem_addr != p_addr || mem_we != p_we ||
             (p_we && mem_wdata != p_wdata)))
            n_stab <= n_stab + 1;
        p_stall <= mem_req && !mem_ready;
        p_addr  <= mem_addr;
        p_we    <= mem_we;
        p_wdata <= mem_wdata;
        if (mem_req && !mem_ready) n_stall <= n_stall + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int b_wr, b_rd, b_gn, b_gr, b_stall, b_stab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_wr = n_wr; b_rd = n_rd; b_gn = n_gn; b_gr = n_gr;
        b_stall = n_stall; b_stab = n_stab;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_pass_run(input string tag);
        chk({tag, "_pass"}, 32'(pass), 32'd1);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_idx"}, 32'(pattern_idx), 32'(PATTERN_COUNT));
        chk({tag, "_writes"}, 32'(n_wr - b_wr), 32'(OPS));
        chk({tag, "_reads"}, 32'(n_rd - b_rd), 32'(OPS));
        chk({tag, "_gen_next"}, 32'(n_gn - b_gn), 32'(PATTERN_COUNT));
        chk({tag, "_gen_reset"}, 32'(n_gr - b_gr), 32'd1);
        chk({tag, "_stable"}, 32'(n_stab - b_stab), 32'd0);
    endtask

    // first pattern whose bit differs from the stuck value exposes the fault
    task automatic run_fault(input string tag, input logic [AB-1:0] a,
                             input int bitn, input logic v);
        int            k = -1;
        logic [DB-1:0] pv, act;
        for (int i = 0; i < PATTERN_COUNT; i++) begin
            pv = pats[i];
            if (k < 0 && pv[bitn] != v) k = i;
        end
        pv = pats[k];
        act = pv;
        act[bitn] = v;
        flt_en = 1'b1; flt_addr = a; flt_bit = bitn; flt_val = v;
        snap();
        do_start();
        wait_idle(tag);
        chk({tag, "_fail"}, 32'(fail), 32'd1);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_addr"}, 32'(fail_addr), 32'(a));
        chk({tag, "_exp"}, 32'(fail_expected), 32'(pv));
        chk({tag, "_act"}, 32'(fail_actual), 32'(act));
        chk({tag, "_idx"}, 32'(pattern_idx), 32'(k));
        chk({tag, "_writes"}, 32'(n_wr - b_wr), 32'((k + 1) * DEPTH));
        chk({tag, "_reads"}, 32'(n_rd - b_rd), 32'(k * DEPTH + int'(a) + 1));
        flt_en = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_gen_reset", 32'(gen_reset), 32'd0);
        chk("rst_gen_next", 32'(gen_next), 32'd0);
        chk("rst_flags", {30'd0, pass, fail}, 32'd0);
        chk("rst_idx", 32'(pattern_idx), 32'd0);
        chk("rst_fail_info", {4'd0, fail_addr, fail_expected[11:0] | fail_actual[11:0]}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ideal SRAM, full pass
        snap();
        do_start();
        chk("s1_gen_reset_hi", 32'(gen_reset), 32'd1);
        chk("s1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("s1_gen_reset_lo", 32'(gen_reset), 32'd0);
        chk("s1_first_wr", {mem_req, mem_we, 26'd0, mem_addr}, {2'b11, 30'd0});
        wait_idle("s1");
        check_pass_run("s1");

        // bit 3 stuck at 0 at address 5
        run_fault("s2", 4'd5, 3, 1'b0);

        // restart after DONE_FAIL clears results and pulses gen_reset once
        snap();
        do_start();
        chk("s3_cleared", {28'd0, pass, fail, pattern_idx[1:0] | fail_addr[1:0]}, 32'd0);
        chk("s3_fail_data", {fail_expected, fail_actual}, 32'd0);
        chk("s3_gen_reset", 32'(gen_reset), 32'd1);
        wait_idle("s3");
        check_pass_run("s3");

        // every request stalled for 3 cycles
        stall_mode = 1;
        snap();
        do_start();
        wait_idle("s4");
        check_pass_run("s4");
        chk("s4_stalls", 32'(n_stall - b_stall), 32'(2 * OPS * 3));

        // start pulses while busy, random stalls
        stall_mode = 2;
        snap();
        do_start();
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(5, 150)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle("s5");
        check_pass_run("s5");

        // reset during pattern 3 with a read in flight
        stall_mode = 0;
        rd_lat = 4;
        snap();
        do_start();
        n = 0;
        while (!(pattern_idx == 3'd3 && mem_req && !mem_we && mem_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("s6_reach_p3", 32'(n < 5000), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("s6_busy_now", 32'(busy), 32'd0);
        chk("s6_req_now", 32'(mem_req), 32'd0);
        chk("s6_idx_now", 32'(pattern_idx), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!mem_rvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("s6_late_rvalid", 32'(mem_rvalid), 32'd1);
        repeat (3) @(negedge clk);
        chk("s6_idle", {29'd0, busy, pass, fail}, 32'd0);
        chk("s6_gen_reset", 32'(n_gr - b_gr), 32'd1);
        rd_lat = 1;
        snap();
        do_start();
        wait_idle("s6r");
        check_pass_run("s6r");

        // random stuck-at faults with random stalls
        stall_mode = 2;
        for (int i = 0; i < 4; i++) begin
            run_fault($sformatf("rf%0d", i), AB'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(0, DB - 1)), 1'($urandom_range(0, 1)));
        end

        chk("never_both", 32'(n_both), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
